// File: rtl/axi_rd_data_rx_if.sv
// Signal bundle between the AR issuer / R channel / stream consumer and axi_rd_data_rx.
// The slave modport is the receiver's view; master is the surrounding system's view.
interface axi_rd_data_rx_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ID_MAX_WIDTH = 12
);
  // Expected-burst command push from the AR issuer
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [ID_MAX_WIDTH-1:0] cmd_id;
  logic [7:0]              cmd_len;

  // AXI R channel
  logic                    rvalid;
  logic                    rready;
  logic [ID_MAX_WIDTH-1:0] rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;

  // Output stream
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_last;

  // Error reporting and status
  logic                    err_valid;
  logic [3:0]              err_code;
  logic [ID_MAX_WIDTH-1:0] err_id;
  logic [3:0]              err_sticky;
  logic                    err_clr;
  logic                    busy;

  modport slave (
    input  cmd_valid, cmd_id, cmd_len,
    input  rvalid, rid, rdata, rresp, rlast,
    input  out_ready, err_clr,
    output cmd_ready, rready,
    output out_valid, out_data, out_last,
    output err_valid, err_code, err_id, err_sticky, busy
  );

  modport master (
    output cmd_valid, cmd_id, cmd_len,
    output rvalid, rid, rdata, rresp, rlast,
    output out_ready, err_clr,
    input  cmd_ready, rready,
    input  out_valid, out_data, out_last,
    input  err_valid, err_code, err_id, err_sticky, busy
  );
endinterface

// File: rtl/axi_rd_data_rx.sv
// AXI R-channel sink: checks each burst against the queued AR command and
// buffers beats in a first-word-fall-through FIFO feeding a valid/ready stream.
module axi_rd_data_rx #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ID_MAX_WIDTH = 12,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CMD_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  axi_rd_data_rx_if.slave    bus
);

  localparam int unsigned FIFO_AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CW  = FIFO_AW + 1;
  localparam int unsigned CMD_AW   = $clog2(CMD_DEPTH);
  localparam int unsigned CMD_CW   = CMD_AW + 1;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned ERR_W    = 4;

  localparam int unsigned ERR_RESP         = 0;
  localparam int unsigned ERR_ID           = 1;
  localparam int unsigned ERR_EARLY_LAST   = 2;
  localparam int unsigned ERR_MISSING_LAST = 3;

  // ---------------------------------------------------------------- storage
  logic [ID_MAX_WIDTH-1:0] r_cmd_id  [CMD_DEPTH];
  logic [LEN_W-1:0]        r_cmd_len [CMD_DEPTH];
  logic [CMD_AW-1:0]       r_cmd_wp;
  logic [CMD_AW-1:0]       r_cmd_rp;
  logic [CMD_CW-1:0]       r_cmd_cnt;

  logic [DATA_WIDTH-1:0]   r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   r_fifo_last;
  logic [FIFO_AW-1:0]      r_fifo_wp;
  logic [FIFO_AW-1:0]      r_fifo_rp;
  logic [FIFO_CW-1:0]      r_fifo_cnt;

  logic [LEN_W-1:0]        r_beat_cnt;

  logic                    r_err_valid;
  logic [ERR_W-1:0]        r_err_code;
  logic [ID_MAX_WIDTH-1:0] r_err_id;
  logic [ERR_W-1:0]        r_err_sticky;

  // ------------------------------------------------------------- handshakes
  logic                    w_cmd_ready;
  logic                    w_cmd_push;
  logic                    w_cmd_pop;
  logic                    w_cmd_nonempty;
  logic                    w_rready;
  logic                    w_accept;
  logic                    w_out_valid;
  logic                    w_fifo_pop;
  logic                    w_fifo_nonempty;
  logic [ID_MAX_WIDTH-1:0] w_head_id;
  logic [LEN_W-1:0]        w_head_len;
  logic [ERR_W-1:0]        w_err_code;

  assign w_cmd_nonempty  = (r_cmd_cnt != '0);
  assign w_fifo_nonempty = (r_fifo_cnt != '0);

  // rready looks only at registered occupancy, so out_ready never reaches it
  assign w_cmd_ready = !rst && (r_cmd_cnt != CMD_CW'(CMD_DEPTH));
  assign w_cmd_push  = bus.cmd_valid && w_cmd_ready;
  assign w_rready    = !rst && w_cmd_nonempty && (r_fifo_cnt < FIFO_CW'(FIFO_DEPTH));
  assign w_accept    = bus.rvalid && w_rready;
  assign w_cmd_pop   = w_accept && bus.rlast;
  assign w_out_valid = !rst && w_fifo_nonempty;
  assign w_fifo_pop  = w_out_valid && bus.out_ready;

  assign w_head_id  = r_cmd_id[r_cmd_rp];
  assign w_head_len = r_cmd_len[r_cmd_rp];

  // Per-beat protocol checks against the head command
  always_comb begin
    w_err_code                   = '0;
    w_err_code[ERR_RESP]         = (bus.rresp != 2'b00);
    w_err_code[ERR_ID]           = (bus.rid != w_head_id);
    w_err_code[ERR_EARLY_LAST]   = bus.rlast && (r_beat_cnt < w_head_len);
    w_err_code[ERR_MISSING_LAST] = !bus.rlast && (r_beat_cnt >= w_head_len);
  end

  // ---------------------------------------------------------- command queue
  always_ff @(posedge clk) begin
    if (w_cmd_push) begin
      r_cmd_id[r_cmd_wp]  <= bus.cmd_id;
      r_cmd_len[r_cmd_wp] <= bus.cmd_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_wp  <= '0;
      r_cmd_rp  <= '0;
      r_cmd_cnt <= '0;
    end else begin
      if (w_cmd_push) r_cmd_wp <= r_cmd_wp + CMD_AW'(1);
      if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + CMD_AW'(1);
      case ({w_cmd_push, w_cmd_pop})
        2'b10:   r_cmd_cnt <= r_cmd_cnt + CMD_CW'(1);
        2'b01:   r_cmd_cnt <= r_cmd_cnt - CMD_CW'(1);
        default: r_cmd_cnt <= r_cmd_cnt;
      endcase
    end
  end

  // -------------------------------------------------------------- data FIFO
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_fifo_data[r_fifo_wp] <= bus.rdata;
      r_fifo_last[r_fifo_wp] <= bus.rlast;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_wp  <= '0;
      r_fifo_rp  <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_accept)   r_fifo_wp <= r_fifo_wp + FIFO_AW'(1);
      if (w_fifo_pop) r_fifo_rp <= r_fifo_rp + FIFO_AW'(1);
      case ({w_accept, w_fifo_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + FIFO_CW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - FIFO_CW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // --------------------------------------------------- beat position counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      if (bus.rlast)                  r_beat_cnt <= '0;
      else if (r_beat_cnt != 8'hFF)   r_beat_cnt <= r_beat_cnt + LEN_W'(1);
    end
  end

  // ---------------------------------------------------------- error report
  // Sticky clear happens before the same-cycle set, so new bits survive err_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_valid  <= 1'b0;
      r_err_code   <= '0;
      r_err_id     <= '0;
      r_err_sticky <= '0;
    end else begin
      r_err_valid  <= w_accept && (w_err_code != '0);
      r_err_code   <= w_accept ? w_err_code : '0;
      r_err_id     <= (w_accept && (w_err_code != '0)) ? bus.rid : '0;
      r_err_sticky <= (bus.err_clr ? '0 : r_err_sticky) | (w_accept ? w_err_code : '0);
    end
  end

  // ----------------------------------------------------------------- outputs
  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.rready     = w_rready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_data   = w_out_valid ? r_fifo_data[r_fifo_rp] : '0;
  assign bus.out_last   = w_out_valid ? r_fifo_last[r_fifo_rp] : 1'b0;
  assign bus.err_valid  = r_err_valid;
  assign bus.err_code   = r_err_code;
  assign bus.err_id     = r_err_id;
  assign bus.err_sticky = r_err_sticky;
  assign bus.busy       = !rst && (w_cmd_nonempty || w_fifo_nonempty);

endmodule
